// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables, bubbles and flushes for load-use, branch, dmem wait and HLT drain.
// Optional performance counters are compiled in with `define PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int HALT_DRAIN = 3
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_memread,
  input  logic [3:0] ex_rd,
  input  logic       id_branch_taken,
  input  logic       id_hlt,
  input  logic       imem_stall,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_noop,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       memwb_noop,
  output logic       halted,
  output logic [1:0] state
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DWAIT = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam int DW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(HALT_DRAIN - 1);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          drain_pend_q, drain_pend_d;

  logic dwait, luse, frozen, draining, active;
  logic br_case, hlt_start;

  assign dwait = dmem_req & ~dmem_ready;
  assign luse  = ex_memread & (ex_rd != 4'd0) &
                 ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  // In DWAIT only dmem_ready releases the freeze, regardless of dmem_req.
  assign frozen    = (state_q == S_DWAIT) ? ~dmem_ready : dwait;
  assign draining  = (state_q == S_DRAIN) | ((state_q == S_DWAIT) & drain_pend_q);
  assign active    = rst & (state_q != S_HALT);
  assign br_case   = active & ~frozen & ~luse & id_branch_taken;
  assign hlt_start = ~frozen & ~luse & id_hlt & ~draining;

  assign state  = state_q;
  assign halted = (state_q == S_HALT);

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_noop  = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    memwb_noop = 1'b0;
    if (!active) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      idex_noop  = 1'b1;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      memwb_noop = 1'b1;
    end else if (frozen) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_noop = 1'b1;
    end else begin
      if (luse) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_noop = 1'b1;
      end else if (id_branch_taken) begin
        ifid_flush = 1'b1;
      end else if (imem_stall) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      // While HLT drains, fetch stays parked and only bubbles enter the pipe.
      if (draining) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        idex_noop  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    drain_pend_d = drain_pend_q;
    if (state_q != S_HALT) begin
      if (frozen) begin
        state_d      = S_DWAIT;
        drain_pend_d = draining;
      end else begin
        drain_pend_d = 1'b0;
        if (draining) begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d = S_HALT;
          end else begin
            state_d     = S_DRAIN;
            drain_cnt_d = drain_cnt_q + DW'(1);
          end
        end else if (hlt_start) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else begin
          state_d = S_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RUN;
      drain_cnt_q  <= '0;
      drain_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      drain_pend_q <= drain_pend_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Flushes caused by a drain are not branch flushes, so they are not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (active && !pc_en && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (br_case && !draining && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic against a behavioural model.
// Define PIPE_PERF_CNT_EN to also exercise the saturating counters with CNT_W=4.
module tb_pipe_hazard_ctrl;

  localparam int HALT_DRAIN = 3;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_rs, id_rt, ex_rd;
  logic id_use_rs, id_use_rt, ex_memread, id_branch_taken, id_hlt;
  logic imem_stall, dmem_req, dmem_ready;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_noop, exmem_en, memwb_en, memwb_noop;
  logic halted;
  logic [1:0] state;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  bit m_halted;
  bit m_waiting;
  int m_drain_left;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .HALT_DRAIN(HALT_DRAIN)
`ifdef PIPE_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_branch_taken(id_branch_taken),
    .id_hlt(id_hlt), .imem_stall(imem_stall), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_noop(idex_noop), .exmem_en(exmem_en), .memwb_en(memwb_en), .memwb_noop(memwb_noop),
    .halted(halted), .state(state)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic bit model_luse();
    return ex_memread && ex_rd != 0 &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  endfunction

  function automatic bit model_frozen();
    if (m_waiting) return !dmem_ready;
    return dmem_req && !dmem_ready;
  endfunction

  // Expected {pc, ifid, flush, idex, idex_noop, exmem, memwb, memwb_noop}.
  function automatic logic [7:0] model_out();
    logic [7:0] v;
    if (!rst || m_halted) return 8'b0000_1001;
    if (model_frozen()) return 8'b0000_0011;
    if (model_luse())          v = 8'b0001_1110;
    else if (id_branch_taken)  v = 8'b1111_0110;
    else if (imem_stall)       v = 8'b0111_0110;
    else                       v = 8'b1101_0110;
    if (m_drain_left > 0) begin
      v[7] = 1'b0;
      v[5] = 1'b1;
      v[3] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_halted) return 2'd3;
    if (m_waiting) return 2'd1;
    if (m_drain_left > 0) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_halted     = 0;
    m_waiting    = 0;
    m_drain_left = 0;
  endtask

  task automatic model_clock();
    if (!rst || m_halted) return;
    if (model_frozen()) begin
      m_waiting = 1;
    end else begin
      m_waiting = 0;
      if (m_drain_left > 0) begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1;
      end else if (id_hlt && !model_luse()) begin
        m_drain_left = HALT_DRAIN;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ":out"}, {8'h0, pc_en, ifid_en, ifid_flush, idex_en, idex_noop, exmem_en,
                        memwb_en, memwb_noop}, {8'h0, model_out()});
    chk({tag, ":state"}, {14'h0, state}, {14'h0, model_state()});
    chk({tag, ":halted"}, {15'h0, halted}, {15'h0, m_halted});
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rs, input logic [3:0] rt,
                               input logic urs, input logic urt, input logic mr,
                               input logic [3:0] rd, input logic br, input logic hlt,
                               input logic ims, input logic req, input logic rdy);
    rst = r; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_memread = mr; ex_rd = rd; id_branch_taken = br; id_hlt = hlt;
    imem_stall = ims; dmem_req = req; dmem_ready = rdy;
    if (!r) model_reset();
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    model_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset");
    step("reset_hold");
    idle();
    step("normal");

    applyStimulus(1, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0, 0);
    step("luse");
    idle();
    step("luse_after");

    applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step("r0_excl");
    applyStimulus(1, 0, 7, 0, 1, 1, 7, 0, 0, 0, 0, 0);
    step("luse_rt");

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("dwait");
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("dwait_done");
    idle();
    step("dwait_run");

    applyStimulus(1, 3, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0);
    step("prio_luse");
    applyStimulus(1, 3, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    step("prio_branch");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("imem_stall");

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("hlt");
    idle();
    for (int i = 0; i < HALT_DRAIN; i++) step("drain");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    step("halted");
    step("halted_hold");

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst_again");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("hlt2");
    idle();
    step("drain2");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("drain_dwait");
    #2;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("async_rst");
    step("async_rst_hold");

`ifdef PIPE_PERF_CNT_EN
    idle();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step("perf_br");
    end
    @(negedge clk);
    chk("flush_cnt_sat", {12'h0, flush_cnt}, 16'd15);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("perf_rst");
`endif

    begin
      int halt_run = 0;
      for (int i = 0; i < 600; i++) begin
        logic r;
        r = !(($urandom_range(0, 99) == 0) || (m_halted && halt_run > 3));
        halt_run = m_halted ? halt_run + 1 : 0;
        applyStimulus(r,
                      4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 99) < 30), 4'($urandom_range(0, 3)),
                      ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 3),
                      ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 25),
                      ($urandom_range(0, 99) < 50));
        step("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
